// File: rtl/mt9v034_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the MT9V034 capture front-end.
package mt9v034_pkg;

    localparam int unsigned PIX_W   = 10;
    localparam int unsigned TDATA_W = 16;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    typedef struct packed {
        logic             user;
        logic             last;
        logic [PIX_W-1:0] pixel;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/mt9v034_sync_fifo.sv
`timescale 1ns/1ps
// Single-clock show-ahead FIFO; read data reads as zero while empty.
module mt9v034_sync_fifo #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mt9v034_input.sv
`timescale 1ns/1ps
// MT9V034 parallel sensor capture: oversampled pins to AXI4-Stream video.
module mt9v034_input
    import mt9v034_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic               axi4sclk,
    input  logic               axi4s_resetn,
    input  logic               pclk,
    input  logic               FRAME_VALID,
    input  logic               LINE_VALID,
    input  logic               DATA_VALID,
    input  logic [PIX_W-1:0]   PIXEL_DATA,
    input  logic               m_axis_tready,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser
);

    localparam int unsigned SYNC_W = PIX_W + 4;

    logic [SYNC_W-1:0] raw_c;
    logic [SYNC_W-1:0] meta_q;
    logic [SYNC_W-1:0] sync_q;
    logic              pclk_hist_q;
    logic              pclk_s, fv_s, lv_s, dv_s;
    logic [PIX_W-1:0]  pix_s;
    logic              ev_c;
    logic              qual_c;

    state_t            state_q, state_d;
    logic              hold_valid_q;
    logic [PIX_W-1:0]  hold_pix_q;
    logic              sof_pending_q;
    logic              drop_q;

    logic              fwd_c, push_c, push_last_c, load_c, flush_c, sof_set_c;
    fifo_entry_t       push_entry_c;
    fifo_entry_t       rd_entry_c;
    logic              fifo_full, fifo_empty;

    assign raw_c  = {pclk, FRAME_VALID, LINE_VALID, DATA_VALID, PIXEL_DATA};
    assign pclk_s = sync_q[SYNC_W-1];
    assign fv_s   = sync_q[SYNC_W-2];
    assign lv_s   = sync_q[SYNC_W-3];
    assign dv_s   = sync_q[SYNC_W-4];
    assign pix_s  = sync_q[PIX_W-1:0];
    assign ev_c   = pclk_s & ~pclk_hist_q;
    assign qual_c = ev_c & fv_s & lv_s & dv_s;

    // Two-flop synchroniser on every sensor pin plus pclk edge history.
    always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
        if (!axi4s_resetn) begin
            meta_q      <= '0;
            sync_q      <= '0;
            pclk_hist_q <= 1'b0;
        end else begin
            meta_q      <= raw_c;
            sync_q      <= meta_q;
            pclk_hist_q <= pclk_s;
        end
    end

    // Framing state register.
    always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
        if (!axi4s_resetn) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: overflow forces a resync to the next clean frame start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (ev_c && !fv_s) state_d = IDLE;
            IDLE:    if (drop_q) state_d = SYNC;
                     else if (ev_c && fv_s) state_d = ACTIVE;
            ACTIVE:  if (drop_q) state_d = SYNC;
                     else if (ev_c && !fv_s) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    // Holding-register control: push previous pixel on next pixel or line/frame end.
    always_comb begin
        fwd_c       = (state_q == ACTIVE) && !drop_q;
        push_c      = 1'b0;
        push_last_c = 1'b0;
        load_c      = 1'b0;
        flush_c     = 1'b0;
        sof_set_c   = (state_q == IDLE) && ev_c && fv_s && !drop_q;
        if (fwd_c && ev_c) begin
            if (qual_c) begin
                load_c = 1'b1;
                push_c = hold_valid_q;
            end else if (!lv_s || !fv_s) begin
                push_c      = hold_valid_q;
                push_last_c = 1'b1;
                flush_c     = 1'b1;
            end
        end
        push_entry_c.user  = sof_pending_q;
        push_entry_c.last  = push_last_c;
        push_entry_c.pixel = hold_pix_q;
    end

    // Holding register, start-of-frame and overflow flags.
    always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
        if (!axi4s_resetn) begin
            hold_valid_q  <= 1'b0;
            hold_pix_q    <= '0;
            sof_pending_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            if (load_c) begin
                hold_valid_q <= 1'b1;
                hold_pix_q   <= pix_s;
            end else if (flush_c || !fwd_c) begin
                hold_valid_q <= 1'b0;
            end
            if (sof_set_c) begin
                sof_pending_q <= 1'b1;
            end else if (push_c) begin
                sof_pending_q <= 1'b0;
            end
            if (push_c && fifo_full) begin
                drop_q <= 1'b1;
            end else if (state_q == SYNC && state_d == IDLE) begin
                drop_q <= 1'b0;
            end
        end
    end

    mt9v034_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (axi4sclk),
        .rst_n   (axi4s_resetn),
        .wr_en   (push_c),
        .wr_data (push_entry_c),
        .rd_en   (m_axis_tready),
        .rd_data (rd_entry_c),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tlast  = rd_entry_c.last;
    assign m_axis_tuser  = rd_entry_c.user;
    assign m_axis_tdata  = {(TDATA_W-PIX_W)'(0), rd_entry_c.pixel};

endmodule

// File: tb/tb_mt9v034_input.sv
`timescale 1ns/1ps
// Directed bench for mt9v034_input: framing, backpressure, overflow and reset.
module tb_mt9v034_input;

    localparam int LINE_PIX = 752;

    logic        axi4sclk     = 1'b0;
    logic        axi4s_resetn = 1'b0;
    logic        pclk         = 1'b0;
    logic        fv           = 1'b0;
    logic        lv           = 1'b0;
    logic        dv           = 1'b0;
    logic [9:0]  pix          = '0;
    logic        tready       = 1'b1;
    logic [15:0] tdata;
    logic        tvalid, tlast, tuser;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] beats_q [$];
    int          base = 0;
    int          stall_err = 0;
    int          stall_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;
    logic        sending = 1'b0;

    always #5  axi4sclk = ~axi4sclk;
    always #20 pclk     = ~pclk;

    mt9v034_input #(
        .FIFO_DEPTH (1024)
    ) dut (
        .axi4sclk      (axi4sclk),
        .axi4s_resetn  (axi4s_resetn),
        .pclk          (pclk),
        .FRAME_VALID   (fv),
        .LINE_VALID    (lv),
        .DATA_VALID    (dv),
        .PIXEL_DATA    (pix),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Beat recorder and stall-stability monitor, sampled mid-cycle.
    always @(negedge axi4sclk) begin
        logic [17:0] cur;
        cur = {tdata, tlast, tuser};
        if (axi4s_resetn) begin
            if (prev_stall) begin
                stall_cycles++;
                if (!tvalid || cur !== prev_beat) stall_err++;
            end
            if (tvalid && tready) beats_q.push_back(cur);
            prev_stall = tvalid && !tready;
            prev_beat  = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [17:0] exp_beat(input int i, input int npix);
        int k;
        k = i % npix;
        return {16'(k + 1), 1'(k == npix - 1), 1'(i == 0)};
    endfunction

    task automatic drive(input logic f, input logic l, input logic d, input logic [9:0] p);
        @(negedge pclk);
        fv  = f;
        lv  = l;
        dv  = d;
        pix = p;
    endtask

    task automatic send_frame(input int nlines, input int npix);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 10'd0);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int k = 0; k < npix; k++) drive(1'b1, 1'b1, 1'b1, 10'(k + 1));
            for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 10'd0);
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c;
        c = 0;
        while ((beats_q.size() - base) < n && c < budget) begin
            @(posedge axi4sclk);
            c++;
        end
        repeat (40) @(posedge axi4sclk);
    endtask

    task automatic check_frame(input string tag, input int n_exp, input int npix);
        int          got_n, bad, nuser, nlast;
        logic [17:0] b;
        got_n = beats_q.size() - base;
        bad   = 0;
        nuser = 0;
        nlast = 0;
        check({tag, "_count"}, got_n, n_exp);
        for (int i = 0; i < got_n; i++) begin
            b = beats_q[base + i];
            if (b !== exp_beat(i, npix)) bad++;
            if (b[0]) nuser++;
            if (b[1]) nlast++;
        end
        check({tag, "_bad_beats"}, bad, 0);
        check({tag, "_tuser_cnt"}, nuser, 1);
        check({tag, "_tlast_cnt"}, nlast, n_exp / npix);
    endtask

    initial begin
        // Reset values, with a frame already streaming on the pins.
        fv = 1'b1; lv = 1'b1; dv = 1'b1;
        repeat (3) @(posedge axi4sclk);
        #1;
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tlast",  32'(tlast),  0);
        check("rst_tuser",  32'(tuser),  0);
        check("rst_tdata",  32'(tdata),  0);
        @(negedge axi4sclk);
        axi4s_resetn = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 10'(i + 1));
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 10'd0);
        repeat (50) @(posedge axi4sclk);
        check("inprogress_frame_beats", beats_q.size() - base, 0);

        // Two full frames separated by vertical blanking.
        base = beats_q.size();
        send_frame(2, LINE_PIX);
        wait_beats(2 * LINE_PIX, 4000);
        check_frame("frame1", 2 * LINE_PIX, LINE_PIX);
        #380us;
        base = beats_q.size();
        send_frame(2, LINE_PIX);
        wait_beats(2 * LINE_PIX, 4000);
        check_frame("frame2", 2 * LINE_PIX, LINE_PIX);

        // Random backpressure during a frame.
        base = beats_q.size();
        sending = 1'b1;
        fork
            begin
                send_frame(2, LINE_PIX);
                sending = 1'b0;
            end
            begin
                while (sending) begin
                    @(posedge axi4sclk);
                    #1;
                    tready = 1'($urandom_range(0, 1));
                end
            end
        join
        tready = 1'b1;
        wait_beats(2 * LINE_PIX, 6000);
        check_frame("rand_ready", 2 * LINE_PIX, LINE_PIX);

        // Overflow: no ready for a whole frame, then a clean frame.
        tready = 1'b0;
        base = beats_q.size();
        send_frame(2, LINE_PIX);
        tready = 1'b1;
        wait_beats(1024, 3000);
        check_frame("overflow", 1024, LINE_PIX);
        base = beats_q.size();
        send_frame(2, LINE_PIX);
        wait_beats(2 * LINE_PIX, 4000);
        check_frame("post_overflow", 2 * LINE_PIX, LINE_PIX);

        // Single-pixel line carries both tuser and tlast.
        base = beats_q.size();
        send_frame(1, 1);
        wait_beats(1, 200);
        check_frame("one_pixel", 1, 1);

        // Reset asserted mid-line with data buffered.
        tready = 1'b0;
        base = beats_q.size();
        fork
            send_frame(1, LINE_PIX);
            begin
                #13000;
                @(posedge axi4sclk);
                #1;
                check("pre_reset_tvalid", 32'(tvalid), 1);
                #2;
                axi4s_resetn = 1'b0;
                #1;
                check("reset_tvalid", 32'(tvalid), 0);
                check("reset_tdata", 32'(tdata), 0);
                #50;
                @(negedge axi4sclk);
                axi4s_resetn = 1'b1;
            end
        join
        tready = 1'b1;
        repeat (100) @(posedge axi4sclk);
        check("post_reset_beats", beats_q.size() - base, 0);
        base = beats_q.size();
        send_frame(1, LINE_PIX);
        wait_beats(LINE_PIX, 3000);
        check_frame("after_reset", LINE_PIX, LINE_PIX);

        check("stall_seen", 32'(stall_cycles > 0), 1);
        check("stall_stable", stall_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
